muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
Multi-cycle sequencer for the RV32M multiply/divide instructions, placed beside the execute unit in the CPU. It accepts an M-extension R-type instruction and holds the PC/writeback via stall while it iterates. It runs a shift-add multiplier or a restoring divider for XLEN cycles, then applies sign fix-up. It returns one result in a single-cycle res_valid slot that the writeback mux selects in place of the ALU result.

Parameters:
XLEN, `datawidth (32), operand/result width
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
m_valid  in  1  decoded instr is R_type with func7 = 7'b0000001 (M-extension)
func3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  in  XLEN  operand A (register file read port 1)
rs2_data  in  XLEN  operand B (register file read port 2)
flush  in  1  abort current op (trap/redirect)
stall  out  1  freeze PC and suppress register writeback
res_valid  out  1  one-cycle pulse: res is the instruction result
res  out  XLEN  result

Behaviour:
- States: IDLE, CALC, FIXUP, DONE. Reset (async, rst=1): state=IDLE, stall=0, res_valid=0, res=0, counter=0, all operand/accumulator registers 0.
- stall is combinational: (state==IDLE & m_valid & ~flush) | state==CALC | state==FIXUP. stall is 0 in DONE, so the instruction retires that cycle.
- IDLE, m_valid=1 (cycle 0):
  - Latch op.
  - Latch magnitudes |A| and |B| according to signedness: MULH/DIV/REM treat both operands as signed; MULHSU treats A signed and B unsigned; MULHU/DIVU/REMU/MUL treat both as unsigned magnitudes.
  - Latch result sign: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - Special cases go IDLE->DONE directly with a 1-cycle result:
    - Divide by zero (B==0): quotient = all ones; remainder = A.
    - Signed overflow, DIV/REM with A=0x8000_0000 and B=0xFFFF_FFFF: quotient = 0x8000_0000; remainder = 0.
  - Otherwise go to CALC with counter=XLEN.
- CALC: one iteration per cycle, counter decrements; exit to FIXUP when counter reaches 1->0.
  - Multiply: 2*XLEN accumulator. If multiplier LSB=1, add multiplicand to the upper half; then shift right by 1 (XLEN+1-bit add keeps the carry).
  - Divide: restoring. {rem,quo} shift left by 1. Trial subtract rem-|B| at XLEN+1 bits; if non-negative, keep the difference and set quo LSB=1.
- FIXUP (one cycle): negate the 2*XLEN product, quotient or remainder if its sign flag is set. Select the output word:
  - MUL: low half.
  - MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Register the selected word into res, then go to DONE.
- DONE: res_valid=1 for exactly one cycle, res holds the value; next state IDLE. res keeps its value in IDLE until the next DONE.
- Latency: normal op res_valid at cycle XLEN+2 (34 for XLEN=32) after acceptance; stall high cycles 0..XLEN+1. Special case res_valid at cycle 1, stall high cycle 0 only.
- Operands are latched at acceptance; rs1/rs2/func3 changes during CALC are ignored.
- m_valid in DONE is not accepted; the PC advances that cycle, and the next instruction is sampled in IDLE next cycle. No back-to-back acceptance.
- flush=1 in any state: next state IDLE, res_valid=0, counter cleared, and stall drops the same cycle. flush has priority over m_valid acceptance and over DONE.
- rst mid-operation: immediate IDLE, all outputs to reset values, no res_valid.
- All arithmetic is modulo 2^XLEN on the output word. Negation is two's complement at the width being negated.

Decomposition:
- Shared `define header, alongside `datawidth: M-extension func7 constant; func3 op codes (MUL..REMU); state encodings (2 bits).
- One sub-module, muldiv_datapath: accumulator/quotient registers, adder/subtractor, and the negation/select logic.
- muldiv_seq holds the FSM, counter, special-case detection and stall logic.

Test Plan:
- MUL rs1=7, rs2=0xFFFF_FFFD (-3) -> stall cycles 0..33; res_valid at cycle 34; res=0xFFFF_FFEB.
- MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> res=0xFFFF_FFFE; MULH same operands -> res=0x0000_0000; MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> res=0xFFFF_FFFF.
- DIV -7 (0xFFFF_FFF9) / 2 -> res=0xFFFF_FFFD (-3); REM same operands -> res=0xFFFF_FFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> res_valid at cycle 1, res=0xFFFF_FFFF; REMU 5/0 -> res=5; stall high in cycle 0 only.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> res=0x8000_0000 at cycle 1; REM same operands -> res=0.
- Abort: start DIV, then at cycle 10 assert rst for one cycle (repeat with flush instead of rst) -> stall=0 immediately, no res_valid, state IDLE. A following MUL 3x4 completes normally with res=12 at cycle 34.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam int unsigned DataWidth = 32;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCalc  = 2'b01,
    StFixup = 2'b10,
    StDone  = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulator, shift-add / restoring-divide step logic, sign fix-up and result register.
module muldiv_datapath
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = DataWidth
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            fixup,
  input  logic            special_ld,
  input  logic [2:0]      op,
  input  logic            sign_q,
  input  logic            sign_r,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  input  logic [XLEN-1:0] special_res,
  output logic [XLEN-1:0] res
);

  // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, quotient}.
  logic [2*XLEN-1:0] acc_q, acc_nxt;
  logic [XLEN-1:0]   opnd_q;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_pr;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, sel;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    // Partial remainder after the left shift needs XLEN+1 bits for large divisors.
    div_pr    = acc_q[2*XLEN-1:XLEN-1];
    div_trial = div_pr - {1'b0, opnd_q};
    acc_nxt   = acc_q;
    if (op[2]) begin
      if (!div_trial[XLEN]) begin
        acc_nxt = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = {div_pr[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
      end else begin
        acc_nxt = {1'b0, acc_q[2*XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod = sign_q ? -acc_q : acc_q;
    quo  = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sign_r ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    sel  = '0;
    case (op)
      OpMul:                   sel = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: sel = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:           sel = quo;
      OpRem, OpRemu:           sel = rem;
      default:                 sel = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      res    <= '0;
    end else begin
      if (load) begin
        acc_q  <= {{XLEN{1'b0}}, a_mag};
        opnd_q <= b_mag;
      end else if (step) begin
        acc_q <= acc_nxt;
      end
      if (special_ld) begin
        res <= special_res;
      end else if (fixup) begin
        res <= sel;
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, special cases and stall.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN  = DataWidth,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m_valid,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic            res_valid,
  output logic [XLEN-1:0] res
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q;
  logic             sign_q_q, sign_r_q;

  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic            div_zero, div_ovf, special;
  logic            load, step, fixup, special_ld;

  always_comb begin
    a_signed = (func3 == OpMulh) || (func3 == OpMulhsu) || (func3 == OpDiv) || (func3 == OpRem);
    b_signed = (func3 == OpMulh) || (func3 == OpDiv) || (func3 == OpRem);
    sa       = a_signed & rs1_data[XLEN-1];
    sb       = b_signed & rs2_data[XLEN-1];
    a_mag    = sa ? -rs1_data : rs1_data;
    b_mag    = sb ? -rs2_data : rs2_data;
    div_zero = func3[2] && (rs2_data == '0);
    div_ovf  = ((func3 == OpDiv) || (func3 == OpRem)) && (rs2_data == '1) &&
               (rs1_data == {1'b1, {(XLEN-1){1'b0}}});
    special  = div_zero || div_ovf;
    // func3[1] distinguishes REM/REMU from DIV/DIVU.
    if (div_zero) begin
      special_res = func3[1] ? rs1_data : '1;
    end else begin
      special_res = func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    step       = 1'b0;
    fixup      = 1'b0;
    special_ld = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (m_valid) begin
          if (special) begin
            special_ld = 1'b1;
            state_d    = StDone;
          end else begin
            load    = 1'b1;
            cnt_d   = CNT_W'(XLEN);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        step  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StFixup;
        end
      end
      StFixup: begin
        fixup   = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d    = StIdle;
      cnt_d      = '0;
      load       = 1'b0;
      step       = 1'b0;
      fixup      = 1'b0;
      special_ld = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= OpMul;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        op_q     <= op_e'(func3);
        sign_q_q <= sa ^ sb;
        sign_r_q <= sa;
      end
    end
  end

  assign stall     = ~flush & (((state_q == StIdle) & m_valid) | (state_q == StCalc) |
                               (state_q == StFixup));
  assign res_valid = ~flush & (state_q == StDone);

  muldiv_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .fixup       (fixup),
    .special_ld  (special_ld),
    .op          (op_q),
    .sign_q      (sign_q_q),
    .sign_r      (sign_r_q),
    .a_mag       (a_mag),
    .b_mag       (b_mag),
    .special_res (special_res),
    .res         (res)
  );

endmodule
